// File: rtl/core_seq_pkg.sv
// Shared types and constants for the multi-cycle core sequencer.
package core_seq_pkg;

    // Sequencer phases; HALT is absorbing until reset.
    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt
    } state_e;

    // Fault codes reported on the fault output.
    localparam logic [1:0] FAULT_NONE      = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL   = 2'b01;
    localparam logic [1:0] FAULT_IFETCH_TO = 2'b10;
    localparam logic [1:0] FAULT_DMEM_TO   = 2'b11;

    // Byte-enable masks.
    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_BYTE = 4'b0001;

    // Data-phase byte enables: a store mask takes precedence over a load mask.
    function automatic logic [3:0] data_be(logic [3:0] r_enb, logic [3:0] w_enb);
        return (w_enb != 4'b0000) ? w_enb : r_enb;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive no-ack cycles of a memory request and flags expiry.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned   CW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam bit            ENABLED = (TIMEOUT != 0);
    localparam logic [CW-1:0] LAST    = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;

    // Wait counter: cleared outside a request, bumped on each un-acked request cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + CW'(1);
        end
    end

    // Expiry is the cycle whose missing ack would take the count to TIMEOUT;
    // an ack in that cycle deasserts en, so the ack wins.
    assign expired = ENABLED && en && (count_q == LAST);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving a shared memory port.
module core_sequencer
    import core_seq_pkg::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [3:0]       mem_r_enb,
    input  logic [3:0]       mem_w_enb,
    input  logic             regs_w_enb,
    input  logic             invalid_op,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic [3:0]       mem_be,
    output logic             mem_addr_sel,
    output logic             ir_we,
    output logic             regs_we,
    output logic             pc_we,
    output logic             halted,
    output logic [1:0]       fault,
    output logic [CNT_W-1:0] retired
);

    state_e     state_q, state_d;
    logic [1:0] fault_d;

    // Decode inputs captured in DECODE so the data request stays stable.
    logic [3:0] r_mask_q;
    logic [3:0] w_mask_q;
    logic       regs_w_q;

    logic wait_active;
    logic wait_clr;
    logic wait_en;
    logic wait_expired;

    assign wait_active = (state_q == StFetch) || (state_q == StMem);
    assign wait_clr    = !wait_active;
    assign wait_en     = wait_active && !mem_ack;

    mem_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (wait_clr),
        .en     (wait_en),
        .expired(wait_expired)
    );

    // Instruction-register capture follows the fetch ack directly.
    assign ir_we = (state_q == StFetch) && mem_ack;

    // Next-state and fault selection.
    always_comb begin
        state_d = state_q;
        fault_d = fault;
        case (state_q)
            StIdle: begin
                if (run) state_d = StFetch;
            end
            StFetch: begin
                if (mem_ack) begin
                    state_d = StDecode;
                end else if (wait_expired) begin
                    state_d = StHalt;
                    fault_d = FAULT_IFETCH_TO;
                end
            end
            StDecode: begin
                if (invalid_op) begin
                    state_d = StHalt;
                    fault_d = FAULT_ILLEGAL;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                if ((r_mask_q != 4'b0000) || (w_mask_q != 4'b0000)) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                if (mem_ack) begin
                    state_d = StWb;
                end else if (wait_expired) begin
                    state_d = StHalt;
                    fault_d = FAULT_DMEM_TO;
                end
            end
            StWb: begin
                state_d = run ? StFetch : StIdle;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, registered Moore strobes decoded from the next state, and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            fault        <= FAULT_NONE;
            halted       <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_be       <= 4'b0000;
            mem_addr_sel <= 1'b0;
            regs_we      <= 1'b0;
            pc_we        <= 1'b0;
            retired      <= '0;
            r_mask_q     <= 4'b0000;
            w_mask_q     <= 4'b0000;
            regs_w_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            fault        <= fault_d;
            halted       <= (state_d == StHalt);
            mem_req      <= (state_d == StFetch) || (state_d == StMem);
            mem_we       <= (state_d == StMem) && (w_mask_q != 4'b0000);
            mem_addr_sel <= (state_d == StMem);
            regs_we      <= (state_d == StWb) && regs_w_q;
            pc_we        <= (state_d == StWb);

            if (state_d == StFetch) begin
                mem_be <= BE_WORD;
            end else if (state_d == StMem) begin
                mem_be <= data_be(r_mask_q, w_mask_q);
            end else begin
                mem_be <= 4'b0000;
            end

            if (state_q == StDecode) begin
                r_mask_q <= mem_r_enb;
                w_mask_q <= mem_w_enb;
                regs_w_q <= regs_w_enb;
            end

            // Retire count becomes visible the cycle after WB; wraps naturally.
            if (state_q == StWb) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: table vectors, hand sequences, random run.
module tb_core_sequencer;
    import core_seq_pkg::*;

    localparam int unsigned CNT_W = 3;
    localparam int          TO    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             run;
    logic [3:0]       mem_r_enb;
    logic [3:0]       mem_w_enb;
    logic             regs_w_enb;
    logic             invalid_op;
    logic             mem_ack;
    logic             mem_req;
    logic             mem_we;
    logic [3:0]       mem_be;
    logic             mem_addr_sel;
    logic             ir_we;
    logic             regs_we;
    logic             pc_we;
    logic             halted;
    logic [1:0]       fault;
    logic [CNT_W-1:0] retired;

    always #5 clk = ~clk;

    core_sequencer #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .mem_r_enb   (mem_r_enb),
        .mem_w_enb   (mem_w_enb),
        .regs_w_enb  (regs_w_enb),
        .invalid_op  (invalid_op),
        .mem_ack     (mem_ack),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_be      (mem_be),
        .mem_addr_sel(mem_addr_sel),
        .ir_we       (ir_we),
        .regs_we     (regs_we),
        .pc_we       (pc_we),
        .halted      (halted),
        .fault       (fault),
        .retired     (retired)
    );

    typedef struct packed {
        logic       req;
        logic       we;
        logic [3:0] be;
        logic       asel;
        logic       irwe;
        logic       regswe;
        logic       pcwe;
        logic       hlt;
        logic [1:0] flt;
    } outs_t;

    outs_t act;
    assign act = {mem_req, mem_we, mem_be, mem_addr_sel, ir_we, regs_we, pc_we, halted, fault};

    typedef struct {
        string      name;
        logic [3:0] r_enb;
        logic [3:0] w_enb;
        logic       regs_w;
        logic       inv;
        int         fw;
        int         dw;
        logic       run_after;
        int         exp_lat;
        logic [1:0] exp_fault;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: phase-level view only.
    bit               m_idle;
    bit               m_halt;
    logic [1:0]       m_fault;
    logic [CNT_W-1:0] m_ret;
    int               steps_in_instr;
    int               lat_meas;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic outs_t o_zero();
        outs_t o;
        o = '0;
        return o;
    endfunction

    function automatic outs_t o_fetch(logic irwe);
        outs_t o;
        o      = '0;
        o.req  = 1'b1;
        o.be   = 4'b1111;
        o.irwe = irwe;
        return o;
    endfunction

    function automatic outs_t o_mem(logic [3:0] r, logic [3:0] w);
        outs_t o;
        o      = '0;
        o.req  = 1'b1;
        o.asel = 1'b1;
        o.we   = (w != 4'b0000);
        o.be   = (w != 4'b0000) ? w : r;
        return o;
    endfunction

    function automatic outs_t o_wb(logic rw);
        outs_t o;
        o        = '0;
        o.pcwe   = 1'b1;
        o.regswe = rw;
        return o;
    endfunction

    function automatic outs_t o_halt();
        outs_t o;
        o     = '0;
        o.hlt = 1'b1;
        o.flt = m_fault;
        return o;
    endfunction

    function automatic vec_t mkv(string name, logic [3:0] r, logic [3:0] w, logic rw, logic inv,
                                 int fw, int dw, logic run_after, int lat, logic [1:0] flt);
        vec_t v;
        v.name      = name;
        v.r_enb     = r;
        v.w_enb     = w;
        v.regs_w    = rw;
        v.inv       = inv;
        v.fw        = fw;
        v.dw        = dw;
        v.run_after = run_after;
        v.exp_lat   = lat;
        v.exp_fault = flt;
        return v;
    endfunction

    // Latency and fault straight from the phase rules.
    function automatic int rule_latency(vec_t v);
        bit is_mem;
        is_mem = (v.r_enb != 4'b0000) || (v.w_enb != 4'b0000);
        if (v.fw >= TO) return TO;
        if (v.inv) return v.fw + 2;
        if (is_mem && v.dw >= TO) return v.fw + 3 + TO;
        return v.fw + 4 + (is_mem ? v.dw + 1 : 0);
    endfunction

    function automatic logic [1:0] rule_fault(vec_t v);
        bit is_mem;
        is_mem = (v.r_enb != 4'b0000) || (v.w_enb != 4'b0000);
        if (v.fw >= TO) return 2'b10;
        if (v.inv) return 2'b01;
        if (is_mem && v.dw >= TO) return 2'b11;
        return 2'b00;
    endfunction

    // One clock: drive ack, sample at the falling edge, return to posedge+1.
    task automatic step(input string tag, input logic ack, input outs_t exp);
        mem_ack = ack;
        @(negedge clk);
        steps_in_instr++;
        if (lat_meas == 0 && (act.pcwe || act.hlt)) begin
            lat_meas = act.hlt ? steps_in_instr - 1 : steps_in_instr;
        end
        check({tag, " outs"}, {19'b0, act}, {19'b0, exp});
        check({tag, " retired"}, 32'(retired), 32'(m_ret));
        @(posedge clk);
        #1;
    endtask

    // Asserted away from any edge so the asynchronous clear is observable at once.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("reset outs", {19'b0, act}, 32'd0);
        check("reset retired", 32'(retired), 32'd0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        run     = 1'b0;
        mem_ack = 1'b0;
        m_idle  = 1'b1;
        m_halt  = 1'b0;
        m_fault = 2'b00;
        m_ret   = '0;
    endtask

    task automatic halt_cycles(input int n);
        run = 1'b1;
        for (int k = 0; k < n; k++) step("halt", rbit(), o_halt());
    endtask

    // Walk one instruction through its phases, ack timing taken from the vector.
    task automatic run_instr(input vec_t v);
        bit done;
        mem_r_enb  = v.r_enb;
        mem_w_enb  = v.w_enb;
        regs_w_enb = v.regs_w;
        invalid_op = v.inv;
        if (m_idle) begin
            run = 1'b1;
            step({v.name, " idle"}, rbit(), o_zero());
            m_idle = 1'b0;
        end
        steps_in_instr = 0;
        lat_meas       = 0;

        done = 1'b0;
        for (int i = 0; i < TO; i++) begin
            if (i == v.fw) begin
                step({v.name, " fetch ack"}, 1'b1, o_fetch(1'b1));
                done = 1'b1;
                break;
            end
            step({v.name, " fetch wait"}, 1'b0, o_fetch(1'b0));
        end
        if (!done) begin
            m_halt  = 1'b1;
            m_fault = 2'b10;
            return;
        end

        step({v.name, " decode"}, rbit(), o_zero());
        if (v.inv) begin
            m_halt  = 1'b1;
            m_fault = 2'b01;
            return;
        end

        run = v.run_after;
        step({v.name, " exec"}, rbit(), o_zero());

        if (v.r_enb != 4'b0000 || v.w_enb != 4'b0000) begin
            done = 1'b0;
            for (int i = 0; i < TO; i++) begin
                if (i == v.dw) begin
                    step({v.name, " mem ack"}, 1'b1, o_mem(v.r_enb, v.w_enb));
                    done = 1'b1;
                    break;
                end
                step({v.name, " mem wait"}, 1'b0, o_mem(v.r_enb, v.w_enb));
            end
            if (!done) begin
                m_halt  = 1'b1;
                m_fault = 2'b11;
                return;
            end
        end

        step({v.name, " wb"}, rbit(), o_wb(v.regs_w));
        m_ret  = m_ret + 1'b1;
        m_idle = !v.run_after;
    endtask

    vec_t vecs[12];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        rst        = 1'b1;
        run        = 1'b0;
        mem_ack    = 1'b0;
        mem_r_enb  = '0;
        mem_w_enb  = '0;
        regs_w_enb = 1'b0;
        invalid_op = 1'b0;
        m_idle     = 1'b1;
        m_halt     = 1'b0;
        m_fault    = 2'b00;
        m_ret      = '0;
        steps_in_instr = 0;
        lat_meas   = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        //               name                 r        w        rw    inv  fw dw run  lat flt
        vecs[0]  = mkv("alu",               4'h0, 4'h0, 1'b1, 1'b0, 0, 0, 1'b1, 4, 2'b00);
        vecs[1]  = mkv("load_half_stall",   4'h3, 4'h0, 1'b1, 1'b0, 0, 3, 1'b1, 8, 2'b00);
        vecs[2]  = mkv("store_word",        4'h0, 4'hf, 1'b0, 1'b0, 1, 0, 1'b1, 6, 2'b00);
        vecs[3]  = mkv("load_byte",         4'h1, 4'h0, 1'b1, 1'b0, 2, 1, 1'b1, 8, 2'b00);
        vecs[4]  = mkv("branch_ack_last",   4'h0, 4'h0, 1'b0, 1'b0, 3, 0, 1'b1, 7, 2'b00);
        vecs[5]  = mkv("store_over_load",   4'hf, 4'h3, 1'b0, 1'b0, 0, 0, 1'b1, 5, 2'b00);
        vecs[6]  = mkv("alu_run_drop",      4'h0, 4'h0, 1'b1, 1'b0, 0, 0, 1'b0, 4, 2'b00);
        vecs[7]  = mkv("alu_after_idle",    4'h0, 4'h0, 1'b1, 1'b0, 1, 0, 1'b1, 5, 2'b00);
        vecs[8]  = mkv("illegal",           4'h0, 4'h0, 1'b1, 1'b1, 0, 0, 1'b1, 2, 2'b01);
        vecs[9]  = mkv("fetch_timeout",     4'h0, 4'h0, 1'b1, 1'b0, 9, 0, 1'b1, 4, 2'b10);
        vecs[10] = mkv("data_timeout",      4'hf, 4'h0, 1'b1, 1'b0, 0, 9, 1'b1, 7, 2'b11);
        vecs[11] = mkv("load_after_reset",  4'h3, 4'h0, 1'b1, 1'b0, 0, 0, 1'b1, 5, 2'b00);

        for (int i = 0; i < 12; i++) begin
            run_instr(vecs[i]);
            if (m_halt) halt_cycles(10);
            check({vecs[i].name, " latency"}, 32'(lat_meas), 32'(vecs[i].exp_lat));
            check({vecs[i].name, " fault"}, 32'(fault), 32'(vecs[i].exp_fault));
            if (m_halt) do_reset();
        end

        // Idle ignores ack and holds strobes low; reset mid-fetch drops the request.
        do_reset();
        for (int k = 0; k < 3; k++) step("idle hold", 1'b1, o_zero());
        run = 1'b1;
        step("midrst idle", 1'b0, o_zero());
        step("midrst fetch", 1'b0, o_fetch(1'b0));
        do_reset();

        // Eight back-to-back instructions wrap a 3-bit retire counter.
        for (int k = 0; k < 8; k++) begin
            run_instr(mkv("wrap", 4'h0, 4'h0, 1'b1, 1'b0, 0, 0, 1'b1, 4, 2'b00));
            if (k == 6) check("wrap seven", 32'(retired), 32'd7);
        end
        check("wrap zero", 32'(retired), 32'd0);

        // Random instruction mix against the phase model.
        for (int n = 0; n < 60; n++) begin
            int k;
            k = int'($urandom_range(0, 15));
            v = mkv("rand", 4'h0, 4'h0, rbit(), 1'b0,
                    ($urandom_range(0, 11) == 0) ? TO + 2 : int'($urandom_range(0, 3)),
                    ($urandom_range(0, 11) == 0) ? TO + 1 : int'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) != 0), 0, 2'b00);
            if (k < 5) begin
                v.r_enb = 4'($urandom_range(1, 15));
            end else if (k < 9) begin
                v.w_enb = 4'($urandom_range(1, 15));
                v.r_enb = 4'($urandom_range(0, 15));
            end else if (k == 15) begin
                v.inv = 1'b1;
            end
            run_instr(v);
            if (m_halt) halt_cycles(3);
            check("rand latency", 32'(lat_meas), 32'(rule_latency(v)));
            check("rand fault", 32'(fault), 32'(rule_fault(v)));
            if (m_halt) do_reset();
        end

        run = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control sequencer for the RV32I core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives a single shared memory port for both instruction fetch and load/store. It gates the decoder's combinational enables so that register and PC writes happen only in their phase. It sits between `control_unit` (its decode inputs) and the datapath/memory port (its strobes).

## Interface
Parameters:
- `CNT_W`, 32: width of the retired-instruction counter.
- `TIMEOUT`, 16: cycles allowed waiting for `mem_ack`; 0 disables the timeout.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `run`  in  1: level; when high, the sequencer keeps issuing instructions.
- `mem_r_enb`  in  4: byte mask for loads, from decode.
- `mem_w_enb`  in  4: byte mask for stores, from decode.
- `regs_w_enb`  in  1: register write request, from decode.
- `invalid_op`  in  1: undefined opcode, from decode.
- `mem_ack`  in  1: memory completes the current request this cycle.
- `mem_req`  out  1: memory request valid.
- `mem_we`  out  1: request is a write.
- `mem_be`  out  4: byte enables for the request.
- `mem_addr_sel`  out  1: address source; 0 = PC, 1 = ALU result.
- `ir_we`  out  1: capture the instruction word at this edge.
- `regs_we`  out  1: gated register-file write.
- `pc_we`  out  1: PC update; the datapath already selects PC+4, branch or jump target.
- `halted`  out  1: sticky halt.
- `fault`  out  2: 00 none, 01 illegal opcode, 10 fetch timeout, 11 data timeout.
- `retired`  out  CNT_W: number of completed instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. Each state is registered.
- **IDLE:** all strobes are 0. Go to FETCH when `run`=1.
- **FETCH:** `mem_req`=1, `mem_we`=0, `mem_be`=4'b1111, `mem_addr_sel`=0.
  - When `mem_ack`=1: pulse `ir_we` in the same cycle, then go to DECODE.
- **DECODE:** one cycle; the decode inputs are valid here.
  - If `invalid_op`=1: go to HALT with `fault`=01.
  - Otherwise: go to EXEC.
- **EXEC:** one cycle, for ALU settle and branch resolve.
  - If `mem_r_enb`≠0 or `mem_w_enb`≠0: go to MEM.
  - Otherwise: go to WB.
- **MEM:** `mem_req`=1, `mem_addr_sel`=1.
  - `mem_we` = (`mem_w_enb`≠0).
  - `mem_be` = `mem_w_enb` if nonzero, else `mem_r_enb`.
  - When `mem_ack`=1: go to WB.
- **WB:** one cycle.
  - `regs_we` = `regs_w_enb`.
  - `pc_we`=1.
  - `retired` increments.
  - Next state is FETCH if `run`=1, else IDLE.
- **Timeout:** a wait counter clears on entry to FETCH or MEM and increments each cycle that `mem_ack`=0.
  - When the counter reaches `TIMEOUT`: go to HALT with `fault`=10 (from FETCH) or 11 (from MEM), and drop `mem_req` that cycle.
- **HALT:** absorbing state. `halted`=1, `fault` is held, all strobes are 0. Only `rst` exits it.
- **`run` deasserted mid-instruction:** the instruction completes through WB, then the sequencer enters IDLE. There is no abort.
- **Counter:** `retired` wraps modulo 2^CNT_W.
- **`mem_ack` outside FETCH/MEM:** ignored.

## Timing
- **Reset:** state IDLE.
  - `mem_req`, `mem_we`, `mem_be`, `mem_addr_sel`, `ir_we`, `regs_we`, `pc_we`, `halted` reset to 0.
  - `fault`=00 and `retired`=0.
- **Strobe decode:** all strobes are Moore outputs decoded from the state, except `ir_we`, which is `mem_ack` gated by FETCH (combinational).
- **Latency, zero-wait memory:** ALU/branch/jump/LUI/AUIPC take 4 cycles; load/store take 5 cycles. Each wait cycle adds 1.
- **Memory handshake:** while `mem_req`=1, `mem_we`/`mem_be`/`mem_addr_sel` are held stable until the ack cycle. A new request starts no earlier than the cycle after the ack.
- **Ack on the timeout cycle:** `mem_ack` arriving in the same cycle the counter hits `TIMEOUT` counts as success; ack wins.
- **Reset mid-operation:** asynchronous return to IDLE. Any in-flight request is dropped immediately.

## Structure
- Package `core_seq_pkg` holds:
  - the state enum;
  - the fault codes: FAULT_NONE/ILLEGAL/IFETCH_TO/DMEM_TO;
  - the byte-mask constants BE_WORD=4'b1111, BE_HALF=4'b0011, BE_BYTE=4'b0001.
- Sub-module `mem_wait_timer`: clear/enable inputs, `expired` output, parameter `TIMEOUT`.
- Top-level module holds the FSM, the output decode and the `retired` counter.

## Test plan
- **ALU instruction:** reset, `run`=1, ack in the same cycle as request, decode `regs_w_enb`=1 with no memory masks → sequence FETCH, DECODE, EXEC, WB over 4 cycles; one `regs_we` pulse; `retired`=1.
- **Load with stall:** `mem_r_enb`=0011, data ack after 3 wait cycles → MEM holds `mem_be`=0011, `mem_we`=0, `mem_addr_sel`=1 for 4 cycles; then WB.
- **Store:** `mem_w_enb`=1111, `regs_w_enb`=0 → `mem_we`=1 and `mem_be`=1111 in MEM; `regs_we` stays 0 in WB; `pc_we`=1.
- **Illegal opcode:** `invalid_op`=1 → HALT, `fault`=01, `halted`=1 held across 10 more cycles with `run`=1. Asserting `rst` returns to IDLE with `fault`=00.
- **Timeout:** `TIMEOUT`=4 with no fetch ack → `mem_req` high for 4 cycles, then HALT with `fault`=10. A second run with ack arriving on the 4th cycle completes normally.
- **`run` drop and wrap:** drop `run` during EXEC → WB completes, then IDLE. With `CNT_W`=3, 8 instructions → `retired` wraps to 0.
